// File: rtl/pattgen.sv
// Serial pattern transmitter: shifts a 1..W bit pattern out MSB first, one bit per clock.
// Define PATTGEN_PARITY_EN to append an even-parity bit after the data bits of every frame.
module pattgen #(
    parameter int W   = 8,
    parameter int LW  = 4,
    parameter int GAP = 1
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic [W-1:0]  pat,
    input  logic [LW-1:0] len,
    input  logic          start,
    output logic          ready,
    output logic          o,
    output logic          o_en,
    output logic          done
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
`ifdef PATTGEN_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP,
        ST_PAR
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          o_q, o_d;
    logic          o_en_q, o_en_d;
    logic          done_q, done_d;
    logic          ready_q, ready_d;
    logic          frame_end;
    logic [LW-1:0] len_l;
    logic [W-1:0]  pat_aligned;
`ifdef PATTGEN_PARITY_EN
    logic          parity_q, parity_d;
`endif

    // Out-of-range lengths send the full pattern; left-align so the first bit is at the MSB.
    assign len_l       = (len == '0 || len > LW'(W)) ? LW'(W) : len;
    assign pat_aligned = pat << (LW'(W) - len_l);

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        o_d       = 1'b0;
        o_en_d    = 1'b0;
        done_d    = 1'b0;
        ready_d   = 1'b0;
        frame_end = 1'b0;
`ifdef PATTGEN_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (start) begin
                    shreg_d = pat_aligned;
                    cnt_d   = len_l;
                    state_d = ST_SHIFT;
                    o_d     = pat_aligned[W-1];
                    o_en_d  = 1'b1;
                    done_d  = (len_l == LW'(1)) && !PAR_EN;
                    ready_d = 1'b0;
`ifdef PATTGEN_PARITY_EN
                    parity_d = ^pat_aligned;
`endif
                end
            end
            ST_SHIFT: begin
                // cnt_q counts the bits still on the line, including the one shown now.
                if (cnt_q > LW'(1)) begin
                    shreg_d = {shreg_q[W-2:0], 1'b0};
                    cnt_d   = cnt_q - LW'(1);
                    o_d     = shreg_q[W-2];
                    o_en_d  = 1'b1;
                    done_d  = (cnt_q == LW'(2)) && !PAR_EN;
                end else begin
`ifdef PATTGEN_PARITY_EN
                    state_d = ST_PAR;
                    shreg_d = '0;
                    cnt_d   = '0;
                    o_d     = parity_q;
                    o_en_d  = 1'b1;
                    done_d  = 1'b1;
`else
                    frame_end = 1'b1;
`endif
                end
            end
            ST_PAR: begin
                frame_end = 1'b1;
            end
            ST_GAP: begin
                if (gap_q <= GW'(1)) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase

        if (frame_end) begin
            shreg_d = '0;
            cnt_d   = '0;
            if (GAP > 0) begin
                state_d = ST_GAP;
                gap_d   = GW'(GAP);
            end else begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            o_q     <= 1'b0;
            o_en_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            o_q     <= o_d;
            o_en_q  <= o_en_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

`ifdef PATTGEN_PARITY_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign ready = ready_q;
    assign o     = o_q;
    assign o_en  = o_en_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pattgen.sv
// Scoreboard bench for pattgen: two instances (GAP=1 and GAP=0) share one random stimulus stream;
// a frame-level reference model predicts every cycle's ready/o_en/o/done.
module tb_pattgen;
    localparam int W  = 8;
    localparam int LW = 4;
`ifdef PATTGEN_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int GAPS [2] = '{1, 0};

    typedef struct packed {
        int   at;
        logic b;
        logic d;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_b;
    logic [W-1:0]  pat;
    logic [LW-1:0] len;
    logic          start;
    logic [1:0]    ready, o, o_en, done;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   free_edge [2] = '{0, 0};
    rec_t exp_q [2][$];
    logic [4:0] det_sr = '0;
    int   det_hits = 0;

    always #5 clk = ~clk;

    pattgen #(.W(W), .LW(LW), .GAP(1)) u_dut0 (
        .clk(clk), .rst_b(rst_b), .pat(pat), .len(len), .start(start),
        .ready(ready[0]), .o(o[0]), .o_en(o_en[0]), .done(done[0])
    );

    pattgen #(.W(W), .LW(LW), .GAP(0)) u_dut1 (
        .clk(clk), .rst_b(rst_b), .pat(pat), .len(len), .start(start),
        .ready(ready[1]), .o(o[1]), .o_en(o_en[1]), .done(done[1])
    );

    // Reference model: decides acceptance from its own idea of readiness and queues the frame.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (rst_b && start) begin
                for (int k = 0; k < 2; k++) begin
                    if (cyc > free_edge[k]) begin
                        int   ll;
                        logic par;
                        rec_t r;
                        ll  = (len == 0 || int'(len) > W) ? W : int'(len);
                        par = 1'b0;
                        for (int i = 0; i < ll; i++) begin
                            r.at = cyc + i;
                            r.b  = pat[ll-1-i];
                            r.d  = (i == ll - 1) && (PAR == 0);
                            par  = par ^ r.b;
                            exp_q[k].push_back(r);
                        end
                        if (PAR != 0) begin
                            r.at = cyc + ll;
                            r.b  = par;
                            r.d  = 1'b1;
                            exp_q[k].push_back(r);
                        end
                        free_edge[k] = cyc + ll + PAR + GAPS[k];
                        $display("frame inst=%0d edge=%0d pat=%02h len=%0d bits=%0d", k, cyc, pat, len, ll + PAR);
                    end
                end
            end
        end
    end

    // Monitor: every cycle, compare each instance against the model's expectation.
    initial begin
        forever begin
            @(negedge clk);
            det_sr = {det_sr[3:0], o[0]};
            if (det_sr == 5'b10101) det_hits++;
            for (int k = 0; k < 2; k++) begin
                logic [3:0] got, expv;
                logic       eb, ed, een;
                eb = 1'b0; ed = 1'b0; een = 1'b0;
                while (exp_q[k].size() > 0 && exp_q[k][0].at < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL missed_bit inst=%0d cyc=%0d expected bit at cycle %0d never shown", k, cyc, exp_q[k][0].at);
                    void'(exp_q[k].pop_front());
                end
                if (exp_q[k].size() > 0 && exp_q[k][0].at == cyc) begin
                    een = 1'b1;
                    eb  = exp_q[k][0].b;
                    ed  = exp_q[k][0].d;
                    void'(exp_q[k].pop_front());
                end
                expv = {(cyc >= free_edge[k]), een, eb, ed};
                got  = {ready[k], o_en[k], o[k], done[k]};
                checks++;
                if (got !== expv) begin
                    failures++;
                    $display("FAIL cycle inst=%0d cyc=%0d ready/o_en/o/done got=%b expected=%b", k, cyc, got, expv);
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] p, input logic [LW-1:0] l);
        @(negedge clk);
        pat   = p;
        len   = l;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pat   = W'($urandom);
        len   = LW'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(cyc >= free_edge[0] && cyc >= free_edge[1])) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL idle_timeout cyc=%0d got busy expected idle within 200 cycles", cyc);
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int h;
        start = 1'b0;
        pat   = '0;
        len   = '0;
        rst_b = 1'b1;
        #1 rst_b = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_b = 1'b1;

        // Basic frame, also watched by a 10101 detector on instance 0.
        repeat (6) @(negedge clk);
        h = det_hits;
        send(8'b0001_0101, 4'd5);
        wait_idle();
        repeat (6) @(negedge clk);
        checks++;
        if (det_hits - h != 1) begin
            failures++;
            $display("FAIL detector got=%0d hits expected=1", det_hits - h);
        end

        // Length clamping, single-bit frame, parity patterns.
        send(8'hA5, 4'd0);  wait_idle();
        send(8'hA5, 4'd12); wait_idle();
        send(8'h01, 4'd1);  wait_idle();
        send(8'h00, 4'd1);  wait_idle();
        send(8'h06, 4'd3);  wait_idle();

        // Asynchronous reset after two of five bits.
        send(8'b0001_0101, 4'd5);
        @(negedge clk);
        #2 rst_b = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        free_edge[0] = cyc;
        free_edge[1] = cyc;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({ready[k], o_en[k], o[k], done[k]} !== 4'b1000) begin
                failures++;
                $display("FAIL async_reset inst=%0d ready/o_en/o/done got=%b expected=1000", k, {ready[k], o_en[k], o[k], done[k]});
            end
        end
        repeat (2) @(negedge clk);
        #2 rst_b = 1'b1;
        send(8'b0001_0101, 4'd5);
        wait_idle();

        // start held high: back-to-back frames, busy starts ignored.
        @(negedge clk);
        pat   = 8'b11;
        len   = 4'd2;
        start = 1'b1;
        repeat (12) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Random traffic, including starts while busy.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            pat   = W'($urandom);
            len   = LW'($urandom_range(0, 15));
            start = ($urandom_range(0, 2) != 0);
        end
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (exp_q[k].size() != 0) begin
                failures++;
                $display("FAIL drain inst=%0d got=%0d pending bits expected=0", k, exp_q[k].size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
